vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  640x480@60 VGA raster engine for the Pong top level. Divides the 100 MHz system clock to a pixel strobe,
//  runs h/v raster counters, hands (h_cnt,v_cnt,valid) to the upstream pixel/scene generator, and takes its
//  colour back. Syncs are delayed to match the generator's latency. Drives the board VGA pins directly.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (>=2)
//  H_ACTIVE  640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48  (H_TOTAL=800)
//  V_ACTIVE  480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33  (V_TOTAL=525)
//  PIPE_LAT  2    pixel-strobe latency of upstream generator, coords -> rgb_in (0..7)
// PORTS
//  clk        in   1   system clock, 100 MHz
//  rst        in   1   asynchronous reset, active-low
//  pix_tick   out  1   one-clk pixel strobe; raster and pipeline advance only on it
//  h_cnt      out  10  current column 0..799
//  v_cnt      out  10  current line 0..524
//  valid      out  1   (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), undelayed
//  frame_end  out  1   one-clk pulse: pix_tick && h_cnt==799 && v_cnt==524 (game-state update strobe)
//  rgb_in     in   12  {R,G,B} 4b each from generator, valid PIPE_LAT strobes after its coords
//  vgaRed/vgaGreen/vgaBlue  out 4 each  registered pixel colour
//  hsync, vsync          out  1  registered, active-low syncs
// BEHAVIOUR
//  - Reset (rst=0, async, no clock needed): div_cnt=0, h_cnt=v_cnt=0, pix_tick=0, frame_end=0,
//    delay lines cleared to (valid=0, hsync=1, vsync=1), hsync=vsync=1, vga colour=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps; pix_tick registered, =1 while div_cnt==CLK_DIV-1.
//    After rst release first pix_tick is high on the CLK_DIV-th rising edge's cycle; then period CLK_DIV.
//  - Raster on clk edge where pix_tick=1: h_cnt++; at 799 -> 0 and v_cnt++; v_cnt 524 -> 0 on same edge.
//    h_cnt,v_cnt are registers; valid/frame_end are combinational from them and pix_tick.
//  - Raw syncs: hs_raw=0 iff 656<=h_cnt<=751; vs_raw=0 iff 490<=v_cnt<=491 (widths from parameters).
//  - Alignment: {valid,hs_raw,vs_raw} pass a PIPE_LAT-deep shift register advanced only on pix_tick;
//    PIPE_LAT=0 is a straight wire. Output register (also pix_tick-enabled) loads hsync,vsync from the
//    delayed syncs and colour = delayed_valid ? rgb_in : 12'h000. Total coord->pin latency PIPE_LAT+1 strobes.
//  - Blanking: colour forced 0 whenever delayed valid=0, regardless of rgb_in.
//  - Between strobes every output except pix_tick/frame_end holds its value.
//  - Reset mid-frame: immediate return to reset values; raster restarts at (0,0); no partial sync pulse
//    is completed; stale pipeline contents are discarded.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: rgb_in ignored; colour = 8 vertical bars of width 80 selected by delayed
//   column bits [9:7] of a column counter carried through the same delay line (white,yellow,cyan,green,
//   magenta,red,blue,black), still blanked outside active area; latency unchanged.
//  Undefined: rgb_in path only; no test-pattern logic or extra delay-line width synthesised.
// STRUCTURE
//  vga_pkg: H_/V_ timing localparams and derived H_TOTAL/V_TOTAL/sync start-end, typedef rgb12_t
//   (struct packed {logic[3:0] r,g,b;}), test-pattern colour constant array.
//  Sub-module vga_delay_line #(WIDTH,DEPTH): enable-gated shift register, async active-low clear to a
//   RESET_VAL parameter, DEPTH=0 -> passthrough. Divider, counters, output register stay in this module.
// TESTING
//  1 rst held 0 for 3 clks, release -> hsync=vsync=1, colour 0, first pix_tick on 4th clk, then every 4.
//  2 run 800 strobes from reset -> h_cnt 799->0 and v_cnt 0->1 on the same edge; valid=0 for h_cnt 640..799.
//  3 PIPE_LAT=2 -> hsync falls 3 strobes after h_cnt==656, stays low exactly 96 strobes (384 clks).
//  4 rgb_in held 12'hF0A -> vgaRed=F,vgaGreen=0,vgaBlue=A for 640 strobes per active line, 0 in blanking
//    and on lines 480..524.
//  5 full frame (420000 strobes) -> exactly one frame_end, 1 clk wide; vsync low 1600 strobes starting
//    3 strobes after (h=0,v=490).
//  6 rst pulsed low mid-line at h_cnt=300 with hsync low-phase pending -> outputs reset before next clk
//    edge; after release raster restarts at (0,0). Repeat 4 with VGA_TEST_PATTERN_EN: column 85 -> 12'hFF0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pkg                                                         |
// | Purpose  : 640x480@60 timing constants, colour type, test-pattern palette. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int C_H_SYNC_START = C_H_ACTIVE + C_H_FP;
  localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC - 1;

  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int C_V_SYNC_START = C_V_ACTIVE + C_V_FP;
  localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC - 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb12_t C_TP_COLORS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic cnt_in_range(input logic [9:0] i_cnt,
                                        input logic [9:0] i_lo,
                                        input logic [9:0] i_hi);
    return (i_cnt >= i_lo) && (i_cnt <= i_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_delay_line                                                  |
// | Purpose  : Enable-gated shift register, async clear to RESET_VAL;          |
// |            DEPTH=0 degenerates to a wire.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_passthru
      logic w_unused_ctrl;
      assign w_unused_ctrl = clk ^ rst_n ^ i_en;
      assign o_data        = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VAL;
          end
        end else if (i_en) begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Purpose  : VGA raster engine: pixel-strobe divider, h/v counters, sync and |
// |            valid alignment to generator latency, registered pin outputs.   |
// |            Define VGA_TEST_PATTERN_EN for built-in 8-bar colour pattern.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 2,
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_pix_tick,
  output logic [9:0]  o_h_cnt,
  output logic [9:0]  o_v_cnt,
  output logic        o_valid,
  output logic        o_frame_end,
  input  logic [11:0] i_rgb_in,
  output logic [3:0]  o_vga_red,
  output logic [3:0]  o_vga_green,
  output logic [3:0]  o_vga_blue,
  output logic        o_hsync,
  output logic        o_vsync
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = $clog2(CLK_DIV);

  localparam logic [9:0]       C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_PRE  = DIV_W'(CLK_DIV - 2);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_tick;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_valid;
  logic             w_hs_raw;
  logic             w_vs_raw;

  // Tick is registered one count early so it is high while div_cnt sits at its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div_cnt  <= (r_div_cnt == C_DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
      r_pix_tick <= (r_div_cnt == C_DIV_PRE);
    end
  end

  assign w_h_wrap = (r_h_cnt == C_H_LAST);
  assign w_v_wrap = (r_v_cnt == C_V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_pix_tick) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign w_valid  = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
  assign w_hs_raw = ~cnt_in_range(r_h_cnt, 10'(HS_START), 10'(HS_END));
  assign w_vs_raw = ~cnt_in_range(r_v_cnt, 10'(VS_START), 10'(VS_END));

`ifdef VGA_TEST_PATTERN_EN
  localparam int              DL_W   = 13;
  localparam logic [DL_W-1:0] DL_RST = {10'd0, 3'b011};
`else
  localparam int              DL_W   = 3;
  localparam logic [DL_W-1:0] DL_RST = 3'b011;
`endif

  logic [DL_W-1:0] w_dl_in;
  logic [DL_W-1:0] w_dl_out;
  rgb12_t          w_pix_rgb;
  rgb12_t          r_rgb;
  logic            r_hsync;
  logic            r_vsync;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Column counter laid out as {bar[2:0], offset-in-bar[6:0]} so bits [9:7] pick the bar
  logic [2:0] r_tp_bar;
  logic [6:0] r_tp_sub;
  logic [6:0] w_unused_tp_sub;
  logic [11:0] w_unused_rgb_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tp_bar <= '0;
      r_tp_sub <= '0;
    end else if (r_pix_tick) begin
      if (w_h_wrap) begin
        r_tp_bar <= '0;
        r_tp_sub <= '0;
      end else if (r_tp_sub == 7'(BAR_W - 1)) begin
        r_tp_bar <= r_tp_bar + 3'd1;
        r_tp_sub <= '0;
      end else begin
        r_tp_sub <= r_tp_sub + 7'd1;
      end
    end
  end

  assign w_dl_in         = {r_tp_bar, r_tp_sub, w_valid, w_hs_raw, w_vs_raw};
  assign w_pix_rgb       = C_TP_COLORS[w_dl_out[12:10]];
  assign w_unused_tp_sub = w_dl_out[9:3];
  assign w_unused_rgb_in = i_rgb_in;
`else
  assign w_dl_in   = {w_valid, w_hs_raw, w_vs_raw};
  assign w_pix_rgb = i_rgb_in;
`endif

  vga_delay_line #(
    .WIDTH     (DL_W),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (DL_RST)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_pix_tick),
    .i_data (w_dl_in),
    .o_data (w_dl_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else if (r_pix_tick) begin
      r_hsync <= w_dl_out[1];
      r_vsync <= w_dl_out[0];
      r_rgb   <= w_dl_out[2] ? w_pix_rgb : rgb12_t'(12'h000);
    end
  end

  assign o_pix_tick  = r_pix_tick;
  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_valid     = w_valid;
  assign o_frame_end = r_pix_tick && w_h_wrap && w_v_wrap;
  assign o_vga_red   = r_rgb.r;
  assign o_vga_green = r_rgb.g;
  assign o_vga_blue  = r_rgb.b;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                               |
// | Purpose  : Randomised self-checking bench for vga_timing_gen (three sizes). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct {
    int div; int lat;
    int ha;  int hf; int hs; int hb;
    int va;  int vf; int vs; int vb;
  } cfg_t;

  typedef struct packed {
    logic        tick;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        valid;
    logic        fe;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [11:0] rgb_tab [1024];
  logic [11:0] tp_tab  [8];

  cfg_t cfg_a, cfg_b, cfg_c;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   cnt_hs_b, cnt_fe_a, cnt_vs_a;

  logic [11:0] rgb_a, rgb_b, rgb_c;
  logic        tick_a, valid_a, fe_a, hs_a, vs_a;
  logic        tick_b, valid_b, fe_b, hs_b, vs_b;
  logic        tick_c, valid_c, fe_c, hs_c, vs_c;
  logic [9:0]  h_a, v_a, h_b, v_b, h_c, v_c;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  vga_timing_gen #(
    .CLK_DIV(3), .PIPE_LAT(3),
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .o_pix_tick(tick_a), .o_h_cnt(h_a), .o_v_cnt(v_a),
    .o_valid(valid_a), .o_frame_end(fe_a), .i_rgb_in(rgb_a),
    .o_vga_red(r_a), .o_vga_green(g_a), .o_vga_blue(b_a), .o_hsync(hs_a), .o_vsync(vs_a)
  );

  vga_timing_gen u_dut_b (
    .clk(clk), .rst_n(rst_n), .o_pix_tick(tick_b), .o_h_cnt(h_b), .o_v_cnt(v_b),
    .o_valid(valid_b), .o_frame_end(fe_b), .i_rgb_in(rgb_b),
    .o_vga_red(r_b), .o_vga_green(g_b), .o_vga_blue(b_b), .o_hsync(hs_b), .o_vsync(vs_b)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .PIPE_LAT(0),
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .o_pix_tick(tick_c), .o_h_cnt(h_c), .o_v_cnt(v_c),
    .o_valid(valid_c), .o_frame_end(fe_c), .i_rgb_in(rgb_c),
    .o_vga_red(r_c), .o_vga_green(g_c), .o_vga_blue(b_c), .o_hsync(hs_c), .o_vsync(vs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cfg_t mk_cfg(input int div, input int lat, input int ha, input int hf,
                                  input int hs, input int hb, input int va, input int vf,
                                  input int vs, input int vb);
    cfg_t k;
    k.div = div; k.lat = lat;
    k.ha = ha; k.hf = hf; k.hs = hs; k.hb = hb;
    k.va = va; k.vf = vf; k.vs = vs; k.vb = vb;
    return k;
  endfunction

  // Colour the screen should show for raster position index m (column hm)
  function automatic logic [11:0] pixel(input cfg_t k, input int m, input int hm);
`ifdef VGA_TEST_PATTERN_EN
    return tp_tab[(hm / (k.ha / 8)) % 8];
`else
    return (hm >= 0) ? rgb_tab[m % 1024] : 12'h000;
`endif
  endfunction

  // Expected outputs c clock edges after reset release: n strobes done, pins show index n-(lat+1)
  function automatic exp_t model(input cfg_t k, input int c);
    exp_t e;
    int ht, vt, n, m, hm, vm;
    ht      = k.ha + k.hf + k.hs + k.hb;
    vt      = k.va + k.vf + k.vs + k.vb;
    n       = c / k.div;
    e.tick  = ((c % k.div) == k.div - 1);
    e.h     = 10'(n % ht);
    e.v     = 10'((n / ht) % vt);
    e.valid = ((n % ht) < k.ha) && (((n / ht) % vt) < k.va);
    e.fe    = e.tick && ((n % ht) == ht - 1) && (((n / ht) % vt) == vt - 1);
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    e.rgb   = 12'h000;
    m = n - (k.lat + 1);
    if (m >= 0) begin
      hm      = m % ht;
      vm      = (m / ht) % vt;
      e.hsync = !((hm >= k.ha + k.hf) && (hm < k.ha + k.hf + k.hs));
      e.vsync = !((vm >= k.va + k.vf) && (vm < k.va + k.vf + k.vs));
      if ((hm < k.ha) && (vm < k.va)) e.rgb = pixel(k, m, hm);
    end
    return e;
  endfunction

  // Upstream generator: correct colour only where the next edge is a strobe, junk otherwise
  function automatic logic [11:0] gen_rgb(input cfg_t k, input int c);
    int m;
    if (((c + 1) % k.div) == 0) begin
      m = (c + 1) / k.div - (k.lat + 1);
      if (m >= 0) return rgb_tab[m % 1024];
    end
    return 12'($urandom);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_inst(input string nm, input exp_t e, input logic tick,
                            input logic [9:0] h, input logic [9:0] v, input logic valid,
                            input logic fe, input logic hs, input logic vs,
                            input logic [11:0] rgb);
    check_val({nm, ".tick"},  32'(tick),  32'(e.tick));
    check_val({nm, ".h_cnt"}, 32'(h),     32'(e.h));
    check_val({nm, ".v_cnt"}, 32'(v),     32'(e.v));
    check_val({nm, ".valid"}, 32'(valid), 32'(e.valid));
    check_val({nm, ".frame_end"}, 32'(fe), 32'(e.fe));
    check_val({nm, ".hsync"}, 32'(hs),    32'(e.hsync));
    check_val({nm, ".vsync"}, 32'(vs),    32'(e.vsync));
    check_val({nm, ".rgb"},   32'(rgb),   32'(e.rgb));
  endtask

  task automatic check_all();
    check_inst("A", model(cfg_a, cyc), tick_a, h_a, v_a, valid_a, fe_a, hs_a, vs_a, {r_a, g_a, b_a});
    check_inst("B", model(cfg_b, cyc), tick_b, h_b, v_b, valid_b, fe_b, hs_b, vs_b, {r_b, g_b, b_b});
    check_inst("C", model(cfg_c, cyc), tick_c, h_c, v_c, valid_c, fe_c, hs_c, vs_c, {r_c, g_c, b_c});
  endtask

  task automatic drive_rgb();
    rgb_a = gen_rgb(cfg_a, cyc);
    rgb_b = gen_rgb(cfg_b, cyc);
    rgb_c = gen_rgb(cfg_c, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (cyc < 3200 && !hs_b) cnt_hs_b++;
    if (cyc < 3306 && fe_a)  cnt_fe_a++;
    if (cyc < 3306 && !vs_a) cnt_vs_a++;
    if (cyc == 352) begin
`ifdef VGA_TEST_PATTERN_EN
      check_val("B.col85_rgb", 32'({r_b, g_b, b_b}), 32'h0FF0);
`else
      check_val("B.col85_rgb", 32'({r_b, g_b, b_b}), 32'(rgb_tab[85]));
`endif
    end
    drive_rgb();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    cnt_hs_b = 0;
    cnt_fe_a = 0;
    cnt_vs_a = 0;
    drive_rgb();
  endtask

  // Asynchronous assertion between edges; outputs must already be at reset values
  task automatic do_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    cyc = 0;
    check_all();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_all();
    end
    release_rst();
  endtask

  task automatic frame_checks();
    check_val("B.hsync_low_clks", 32'(cnt_hs_b), 32'(96 * 4));
    check_val("A.frame_end_count", 32'(cnt_fe_a), 32'd1);
    check_val("A.vsync_low_clks", 32'(cnt_vs_a), 32'(2 * 58 * 3));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    cnt_hs_b = 0;
    cnt_fe_a = 0;
    cnt_vs_a = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 1024; i++) rgb_tab[i] = 12'($urandom);
    tp_tab[0] = 12'hFFF; tp_tab[1] = 12'hFF0; tp_tab[2] = 12'h0FF; tp_tab[3] = 12'h0F0;
    tp_tab[4] = 12'hF0F; tp_tab[5] = 12'hF00; tp_tab[6] = 12'h00F; tp_tab[7] = 12'h000;
    cfg_a = mk_cfg(3, 3, 40, 4, 8, 6, 12, 2, 2, 3);
    cfg_b = mk_cfg(4, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    cfg_c = mk_cfg(2, 0, 24, 2, 4, 2, 6, 1, 1, 1);
    rgb_a = 12'($urandom);
    rgb_b = 12'($urandom);
    rgb_c = 12'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all();
    release_rst();

    repeat (10000) step();
    frame_checks();

    while (((cyc / 4) % 800) != 300) step();
    do_reset(2);
    repeat (4000) step();
    frame_checks();

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(200, 3000)) step();
      do_reset(int'($urandom_range(0, 3)));
    end
    repeat (4000) step();
    frame_checks();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
